bus_requester: RTL and testbench

- Per-core bus-master interface unit; it drives the requester side of the shared-bus arbiter (req/type/hold out, grant in).
- Accepts one line-transfer command from the cache controller and requests the bus.
- Holds the bus for BEATS data beats once granted, then releases it.
- One instance per core, wired to the arbiter's req_n/type_n/hold_n/grant_n.

---
 rtl/bus_requester_pkg.sv | 25 ++
 rtl/bus_requester_if.sv | 26 ++
 rtl/bus_beat_ctr.sv | 42 ++++
 rtl/bus_requester.sv | 141 ++++++++++++++
 tb/tb_bus_requester.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/bus_requester_pkg.sv
// Shared types and constants for the bus requester: FSM state encoding,
// bus transfer direction codes and default sizing.
package bus_requester_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_BEATS   = 4;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic BUS_RD = 1'b0;
    localparam logic BUS_WR = 1'b1;

    // Beat counter width; a single-beat transfer still needs one bit.
    function automatic int beat_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/bus_requester_if.sv
// Arbiter request/grant and data-beat signals between one core's requester
// and the shared bus. The arbiter's "type" line is carried as req_type.
interface bus_requester_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              req;
    logic              req_type;
    logic              hold;
    logic              grant;
    logic              bus_valid;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output req, req_type, hold, bus_valid, bus_we, bus_addr, bus_wdata,
        input  grant, bus_rdata
    );

    modport slave (
        input  req, req_type, hold, bus_valid, bus_we, bus_addr, bus_wdata,
        output grant, bus_rdata
    );
endinterface

// File: rtl/bus_beat_ctr.sv
// Beat counter plus beat-address register for one line transfer; the address
// register doubles as the registered bus_addr output.
module bus_beat_ctr
    import bus_requester_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BEATS  = DEF_BEATS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              adv,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    localparam int                BW        = beat_w(BEATS);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(DATA_W / 8);
    localparam logic [BW-1:0]     LAST_BEAT = BW'(BEATS - 1);

    logic [BW-1:0]     beat_reg;
    logic [ADDR_W-1:0] addr_reg;

    // Address arithmetic wraps modulo 2^ADDR_W by construction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            beat_reg <= '0;
            addr_reg <= '0;
        end else if (load) begin
            beat_reg <= '0;
            addr_reg <= base;
        end else if (adv) begin
            beat_reg <= beat_reg + BW'(1);
            addr_reg <= addr_reg + STEP;
        end
    end

    assign addr = addr_reg;
    assign last = (beat_reg == LAST_BEAT);

endmodule

// File: rtl/bus_requester.sv
// Per-core bus master: takes one line command, requests the bus, holds it for
// BEATS beats, then releases. Define REQ_TIMEOUT_EN to bound the grant wait.
module bus_requester
    import bus_requester_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int BEATS   = DEF_BEATS,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              plusclk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_type,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              err,
    bus_requester_if.master   bus
);
    if (DATA_W < 8 || (DATA_W & (DATA_W - 1)) != 0) begin : g_bad_data_w
        $error("DATA_W must be a power of two >= 8");
    end
    if (BEATS < 1 || TIMEOUT < 1) begin : g_bad_counts
        $error("BEATS and TIMEOUT must be >= 1");
    end

    state_t            state_reg, state_next;
    logic              accept, err_next, ctr_adv, ctr_last, tmo_hit;
    logic              req_reg, type_reg, hold_reg, bus_valid_reg, bus_we_reg;
    logic              wr_pop_reg, rd_valid_reg, done_reg, err_reg;
    logic [DATA_W-1:0] bus_wdata_reg, rd_data_reg;

    assign cmd_ready = (state_reg == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

`ifdef REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_reg;

    always_ff @(posedge plusclk) begin
        if (!rst || state_reg != ST_REQ || bus.grant) tmo_reg <= '0;
        else                                         tmo_reg <= tmo_reg + TW'(1);
    end

    assign tmo_hit = (state_reg == ST_REQ) && !bus.grant && (tmo_reg == TW'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    bus_beat_ctr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) u_ctr (
        .clk  (plusclk),
        .rst  (rst),
        .load (accept),
        .adv  (ctr_adv),
        .base (cmd_addr),
        .addr (bus.bus_addr),
        .last (ctr_last)
    );

    always_comb begin
        state_next = state_reg;
        err_next   = 1'b0;
        ctr_adv    = 1'b0;
        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_REQ;
            ST_REQ: begin
                if (bus.grant) begin
                    state_next = ST_XFER;
                end else if (tmo_hit) begin
                    state_next = ST_IDLE;
                    err_next   = 1'b1;
                end
            end
            ST_XFER: begin
                // Losing the grant mid-line is an arbiter fault: abandon the line.
                if (!bus.grant) begin
                    state_next = ST_IDLE;
                    err_next   = 1'b1;
                end else if (ctr_last) begin
                    state_next = ST_DONE;
                end else begin
                    ctr_adv = 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge plusclk) begin
        if (!rst) state_reg <= ST_IDLE;
        else      state_reg <= state_next;
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge plusclk) begin
        if (!rst) begin
            req_reg       <= 1'b0;
            type_reg      <= BUS_RD;
            hold_reg      <= 1'b0;
            bus_valid_reg <= 1'b0;
            bus_we_reg    <= 1'b0;
            wr_pop_reg    <= 1'b0;
            bus_wdata_reg <= '0;
            rd_valid_reg  <= 1'b0;
            rd_data_reg   <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            req_reg       <= (state_next == ST_REQ) || (state_next == ST_XFER);
            hold_reg      <= (state_next == ST_XFER);
            bus_valid_reg <= (state_next == ST_XFER);
            bus_we_reg    <= (state_next == ST_XFER) && (type_reg == BUS_WR);
            wr_pop_reg    <= (state_next == ST_XFER) && (type_reg == BUS_WR);
            if (accept) type_reg <= cmd_type;
            if (state_next == ST_XFER && type_reg == BUS_WR) bus_wdata_reg <= wr_data;
            rd_valid_reg  <= (state_reg == ST_XFER) && (type_reg == BUS_RD);
            if (state_reg == ST_XFER && type_reg == BUS_RD) rd_data_reg <= bus.bus_rdata;
            done_reg      <= (state_next == ST_DONE);
            err_reg       <= err_next;
        end
    end

    assign bus.req       = req_reg;
    assign bus.req_type  = type_reg;
    assign bus.hold      = hold_reg;
    assign bus.bus_valid = bus_valid_reg;
    assign bus.bus_we    = bus_we_reg;
    assign bus.bus_wdata = bus_wdata_reg;
    assign wr_pop        = wr_pop_reg;
    assign rd_valid      = rd_valid_reg;
    assign rd_data       = rd_data_reg;
    assign done          = done_reg;
    assign err           = err_reg;

endmodule

// File: tb/tb_bus_requester.sv
// Cycle-by-cycle check of bus_requester against a timeline model derived from
// the transaction rules (accept, grant wait, beats, abort, reset, timeout).
module tb_bus_requester;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int BEATS   = 4;
    localparam int TIMEOUT = 16;

    logic              plusclk = 1'b0;
    logic              rst = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_type = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_pop;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              done;
    logic              err;

    int total = 0;
    int bad   = 0;
    int txn_no = 0;

    bus_requester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

    bus_requester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS), .TIMEOUT(TIMEOUT)) dut (
        .plusclk   (plusclk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_addr  (cmd_addr),
        .wr_data   (wr_data),
        .wr_pop    (wr_pop),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .done      (done),
        .err       (err),
        .bus       (bif.master)
    );

    always #5 plusclk = ~plusclk;

    task automatic check(input string tag, input int t, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s txn=%0d cyc=%0d observed=%h expected=%h", tag, txn_no, t, obs, exp);
        end
    endtask

    // Cycle 0 offers the command. Grant is driven from cycle 1+d; beat k sits in
    // cycle f+k with f = 2+d. drop_j/rst_k (>=0) abort at that beat.
    task automatic run_txn(input bit wr, input logic [ADDR_W-1:0] base, input int d,
                           input int drop_j, input int rst_k);
        int   g, f, e, last_beat, beat_k, prev_k;
        bit   tmo, normal;
        bit   exp_req, exp_beat, exp_rdv;
        logic [DATA_W-1:0] wprev, rd_prev;
        logic [ADDR_W-1:0] exp_addr;
        g = 1 + d;
        f = g + 1;
        tmo = 1'b0;
`ifdef REQ_TIMEOUT_EN
        tmo = (g > TIMEOUT);
`endif
        last_beat = BEATS - 1;
        if (drop_j >= 0) last_beat = drop_j;
        if (rst_k >= 0)  last_beat = rst_k;
        if (tmo)              e = TIMEOUT + 1;
        else if (rst_k >= 0)  e = f + rst_k + 1;
        else if (drop_j >= 0) e = f + drop_j + 1;
        else                  e = f + BEATS;
        normal = !tmo && drop_j < 0 && rst_k < 0;
        wprev = '0;
        rd_prev = '0;
        $display("txn %0d: wr=%0d addr=%h grant_delay=%0d drop=%0d rst=%0d",
                 txn_no, wr, base, d, drop_j, rst_k);
        for (int t = 0; t <= e + 1; t++) begin
            @(negedge plusclk);
            beat_k   = (!tmo && t >= f && t <= f + last_beat) ? t - f : -1;
            prev_k   = (!tmo && t - 1 >= f && t - 1 <= f + last_beat) ? t - 1 - f : -1;
            exp_beat = (beat_k >= 0);
            exp_req  = exp_beat || (tmo ? (t >= 1 && t <= TIMEOUT) : (t >= 1 && t < f));
            exp_rdv  = !wr && prev_k >= 0 && !(rst_k >= 0 && t == e);
            exp_addr = base + ADDR_W'(beat_k * (DATA_W / 8));
            check("cmd_ready", t, cmd_ready, (t == 0) || (t > e) || (t == e && !normal));
            check("req", t, bif.req, exp_req);
            check("hold", t, bif.hold, exp_beat);
            check("bus_valid", t, bif.bus_valid, exp_beat);
            check("bus_we", t, bif.bus_we, exp_beat && wr);
            check("wr_pop", t, wr_pop, exp_beat && wr);
            check("done", t, done, normal && t == e);
            check("err", t, err, (tmo || drop_j >= 0) && t == e);
            check("rd_valid", t, rd_valid, exp_rdv);
            if (exp_req) check("type", t, bif.req_type, wr);
            if (exp_beat) check("bus_addr", t, bif.bus_addr, exp_addr);
            if (exp_beat && wr) check("bus_wdata", t, bif.bus_wdata, wprev);
            if (exp_rdv) check("rd_data", t, rd_data, rd_prev);
            if (rst_k >= 0 && t == e) begin
                check("rst_addr", t, bif.bus_addr, 0);
                check("rst_type", t, bif.req_type, 0);
            end
            cmd_valid  = (t == 0);
            cmd_type   = wr;
            cmd_addr   = base;
            bif.grant  = !tmo && t >= g && t <= f + last_beat && !(drop_j >= 0 && t == f + drop_j);
            rst        = !(rst_k >= 0 && t == f + rst_k);
            wr_data    = $urandom;
            wprev      = wr_data;
            bif.bus_rdata = $urandom;
            if (exp_beat) rd_prev = bif.bus_rdata;
        end
        cmd_valid = 1'b0;
        bif.grant = 1'b0;
        rst       = 1'b1;
        txn_no++;
    endtask

    initial begin
        bif.grant     = 1'b0;
        bif.bus_rdata = '0;
        repeat (2) @(posedge plusclk);
        @(negedge plusclk);
        check("reset_ready", 0, cmd_ready, 1);
        check("reset_req", 0, bif.req, 0);
        check("reset_hold", 0, bif.hold, 0);
        check("reset_valid", 0, bif.bus_valid, 0);
        check("reset_addr", 0, bif.bus_addr, 0);
        check("reset_done_err", 0, {done, err, rd_valid, wr_pop}, 0);
        rst = 1'b1;
        @(negedge plusclk);

        run_txn(1'b0, 32'h0000_0100, 0, -1, -1);
        run_txn(1'b1, 32'h0000_2000, 4, -1, -1);
        run_txn(1'b0, 32'h0000_3000, 1, 2, -1);
        run_txn(1'b1, 32'h0000_4000, 0, 0, -1);
        run_txn(1'b0, 32'hFFFF_FFFC, 0, -1, -1);
        run_txn(1'b1, 32'hFFFF_FFF8, 2, -1, -1);
        run_txn(1'b1, 32'h0000_5000, 0, -1, 1);
        run_txn(1'b0, 32'h0000_6000, 3, -1, 3);
`ifdef REQ_TIMEOUT_EN
        run_txn(1'b0, 32'h0000_7000, 20, -1, -1);
`endif
        for (int n = 0; n < 24; n++) begin
            int sel, dj, rk;
            sel = $urandom_range(0, 7);
            dj  = (sel < 2) ? $urandom_range(0, BEATS - 1) : -1;
            rk  = (sel == 2) ? $urandom_range(0, BEATS - 1) : -1;
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 6), dj, rk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
